hdc_dataset_sequencer: RTL and testbench

//  Parametrised hardware sequencer that drives oneshot_hdc_top through one full train/binarize/test run.

---
 rtl/hdc_dataset_sequencer.sv | 258 +++++++++++++++++++++++++
 tb/tb_hdc_dataset_sequencer.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/hdc_dataset_sequencer.sv
// -----------------------------------------------------------------------------
// hdc_dataset_sequencer
//
// Drives oneshot_hdc_top through one complete train / binarize / test run.
// Samples are fetched over a request/valid port, start_mapping is pulsed once
// per sample, and the label of sample k reaches class_select_bits LABEL_LAG
// slots later so that it lines up with the encoder pipeline. The run ends
// with the training_dataset_finished and testing_dataset_finished strobes.
//
// Optional feature macro: HDC_SEQ_ACC_EN
//   defined   : counts test inferences whose class matches class_select_bits
//   undefined : correct_count is tied to zero, inference ports are unused
//
// Ports
//   clk, nrst                  clock (rising edge), async active-low reset
//   en                         global enable, low freezes every register
//   start                      launches a run from IDLE or DONE
//   sample_req/idx/is_test     sample request towards sample storage
//   sample_valid/label         sample handshake and its label
//   start_mapping              one-cycle pulse per sample to the core
//   class_select_bits          lagged label to the core
//   training_/testing_dataset_finished  one-cycle strobes to the core
//   inference_valid/class_inference     core inference result
//   correct_count              correct test inferences
//   busy, done                 run status
// -----------------------------------------------------------------------------
module hdc_dataset_sequencer #(
    parameter int CLASS_W     = 5,
    parameter int IDX_W       = 11,
    parameter int TRAIN_COUNT = 1000,
    parameter int TEST_COUNT  = 500,
    parameter int LABEL_LAG   = 2,
    parameter int GAP_CYCLES  = 9,
    parameter int BIN_CYCLES  = 259
) (
    input  logic               clk,
    input  logic               nrst,
    input  logic               en,
    input  logic               start,
    output logic               sample_req,
    output logic [IDX_W-1:0]   sample_idx,
    output logic               sample_is_test,
    input  logic               sample_valid,
    input  logic [CLASS_W-1:0] sample_label,
    output logic               start_mapping,
    output logic [CLASS_W-1:0] class_select_bits,
    output logic               training_dataset_finished,
    output logic               testing_dataset_finished,
    input  logic               inference_valid,
    input  logic [CLASS_W-1:0] class_inference,
    output logic [IDX_W-1:0]   correct_count,
    output logic               busy,
    output logic               done
);

    typedef enum logic [2:0] {
        S_IDLE, S_TRAIN, S_TRAIN_DRAIN, S_BIN, S_TEST, S_TEST_DRAIN, S_FIN, S_DONE
    } state_t;

    // Phases of a data slot: waiting for the sample, mapping pulse, idle gap.
    typedef enum logic [1:0] {PH_REQ, PH_MAP, PH_GAP} phase_t;

    localparam int CNT_MAX = (BIN_CYCLES > GAP_CYCLES + 1) ? BIN_CYCLES : GAP_CYCLES + 1;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int DRN_W   = $clog2(LABEL_LAG + 1);

    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(GAP_CYCLES + 1);
    localparam logic [CNT_W-1:0] BIN_LAST   = CNT_W'(BIN_CYCLES);
    localparam logic [DRN_W-1:0] DRN_LAST   = DRN_W'(LABEL_LAG - 1);
    localparam logic [IDX_W-1:0] TRAIN_N    = IDX_W'(TRAIN_COUNT);
    localparam logic [IDX_W-1:0] TEST_N     = IDX_W'(TEST_COUNT);

    state_t                              state, state_nx;
    phase_t                              phase, phase_nx;
    logic [CNT_W-1:0]                    cnt, cnt_nx;
    logic [IDX_W-1:0]                    idx, idx_nx;
    logic [DRN_W-1:0]                    drn, drn_nx;
    logic                                first, first_nx;
    logic [LABEL_LAG-1:0][CLASS_W-1:0]   sr, sr_nx;
    logic [CLASS_W-1:0]                  csel, csel_nx;

    logic in_slot;
    logic start_accept;

    assign in_slot      = (state == S_TRAIN) || (state == S_TEST);
    assign start_accept = en && start && ((state == S_IDLE) || (state == S_DONE));

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state <= S_IDLE;
            phase <= PH_REQ;
            cnt   <= '0;
            idx   <= '0;
            drn   <= '0;
            first <= 1'b0;
            sr    <= '0;
            csel  <= '0;
        end else begin
            state <= state_nx;
            phase <= phase_nx;
            cnt   <= cnt_nx;
            idx   <= idx_nx;
            drn   <= drn_nx;
            first <= first_nx;
            sr    <= sr_nx;
            csel  <= csel_nx;
        end
    end

    always_comb begin
        state_nx = state;
        phase_nx = phase;
        cnt_nx   = cnt;
        idx_nx   = idx;
        drn_nx   = drn;
        first_nx = first;
        sr_nx    = sr;
        csel_nx  = csel;

        if (en) begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state_nx = (TRAIN_COUNT > 0) ? S_TRAIN : S_TRAIN_DRAIN;
                        phase_nx = PH_REQ;
                        cnt_nx   = '0;
                        idx_nx   = '0;
                        drn_nx   = '0;
                        first_nx = 1'b1;
                        sr_nx    = '0;
                        csel_nx  = '0;
                    end
                end

                S_TRAIN, S_TEST: begin
                    // The label push-out reads the pre-shift SR contents even when
                    // the handshake happens in the same first cycle.
                    if (first) begin
                        csel_nx  = sr[LABEL_LAG-1];
                        first_nx = 1'b0;
                    end
                    case (phase)
                        PH_REQ: begin
                            if (sample_valid) begin
                                for (int i = LABEL_LAG - 1; i > 0; i--) begin
                                    sr_nx[i] = sr[i-1];
                                end
                                sr_nx[0] = sample_label;
                                idx_nx   = idx + IDX_W'(1);
                                phase_nx = PH_MAP;
                            end
                        end
                        PH_MAP: begin
                            phase_nx = PH_GAP;
                            cnt_nx   = '0;
                        end
                        default: begin
                            if (cnt == GAP_LAST) begin
                                cnt_nx   = '0;
                                phase_nx = PH_REQ;
                                first_nx = 1'b1;
                                if (idx == ((state == S_TRAIN) ? TRAIN_N : TEST_N)) begin
                                    idx_nx   = '0;
                                    drn_nx   = '0;
                                    state_nx = (state == S_TRAIN) ? S_TRAIN_DRAIN : S_TEST_DRAIN;
                                end
                            end else begin
                                cnt_nx = cnt + CNT_W'(1);
                            end
                        end
                    endcase
                end

                S_TRAIN_DRAIN, S_TEST_DRAIN: begin
                    // Drain slots flush the SR towards the core, filling with zeros.
                    if (cnt == '0) begin
                        csel_nx = sr[LABEL_LAG-1];
                        for (int i = LABEL_LAG - 1; i > 0; i--) begin
                            sr_nx[i] = sr[i-1];
                        end
                        sr_nx[0] = '0;
                    end
                    if (cnt == DRAIN_LAST) begin
                        cnt_nx = '0;
                        if (drn == DRN_LAST) begin
                            if (state == S_TRAIN_DRAIN) begin
                                state_nx = S_BIN;
                                sr_nx    = '0;
                            end else begin
                                state_nx = S_FIN;
                            end
                        end else begin
                            drn_nx = drn + DRN_W'(1);
                        end
                    end else begin
                        cnt_nx = cnt + CNT_W'(1);
                    end
                end

                // The first BIN cycle carries the training_dataset_finished strobe,
                // followed by BIN_CYCLES of waiting.
                S_BIN: begin
                    if (cnt == BIN_LAST) begin
                        cnt_nx   = '0;
                        idx_nx   = '0;
                        phase_nx = PH_REQ;
                        first_nx = 1'b1;
                        state_nx = (TEST_COUNT > 0) ? S_TEST : S_TEST_DRAIN;
                    end else begin
                        cnt_nx = cnt + CNT_W'(1);
                    end
                end

                S_FIN:   state_nx = S_DONE;
                default: state_nx = S_IDLE;
            endcase
        end
    end

    // Strobes are gated by en so a freeze defers them instead of stretching them.
    assign sample_req                = in_slot && (phase == PH_REQ);
    assign sample_idx                = idx;
    assign sample_is_test            = (state == S_TEST);
    assign start_mapping             = en && in_slot && (phase == PH_MAP);
    assign class_select_bits         = csel;
    assign training_dataset_finished = en && (state == S_BIN) && (cnt == '0);
    assign testing_dataset_finished  = en && (state == S_FIN);
    assign busy                      = (state != S_IDLE) && (state != S_DONE);
    assign done                      = (state == S_DONE);

`ifdef HDC_SEQ_ACC_EN
    function automatic logic [IDX_W-1:0] sat_inc(input logic [IDX_W-1:0] v);
        return (&v) ? v : v + IDX_W'(1);
    endfunction

    logic [IDX_W-1:0] correct;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            correct <= '0;
        end else if (start_accept) begin
            correct <= '0;
        end else if (en && inference_valid &&
                     ((state == S_TEST) || (state == S_TEST_DRAIN)) &&
                     (class_inference == csel)) begin
            correct <= sat_inc(correct);
        end
    end

    assign correct_count = correct;
`else
    logic unused_inference;
    assign unused_inference = ^{inference_valid, class_inference, start_accept};
    assign correct_count    = '0;
`endif

endmodule

// File: tb/tb_hdc_dataset_sequencer.sv
module tb_hdc_dataset_sequencer;
    localparam int CLASS_W = 5;
    localparam int IDX_W   = 11;
    localparam int TRN     = 4;
    localparam int TST     = 2;
    localparam int LAG     = 2;
    localparam int GAP     = 9;
    localparam int BIN     = 259;
    localparam int SLOT    = 2 + GAP;
`ifdef HDC_SEQ_ACC_EN
    localparam int ACC = 1;
`else
    localparam int ACC = 0;
`endif

    logic               clk = 1'b0;
    logic               nrst = 1'b0;
    logic               en = 1'b0;
    logic               start = 1'b0;
    logic               sample_valid = 1'b0;
    logic [CLASS_W-1:0] sample_label = '0;
    logic               inference_valid = 1'b0;
    logic [CLASS_W-1:0] class_inference = '0;
    logic               sample_req, sample_is_test, start_mapping;
    logic               training_dataset_finished, testing_dataset_finished, busy, done;
    logic [IDX_W-1:0]   sample_idx, correct_count;
    logic [CLASS_W-1:0] class_select_bits;

    hdc_dataset_sequencer #(
        .CLASS_W(CLASS_W), .IDX_W(IDX_W), .TRAIN_COUNT(TRN), .TEST_COUNT(TST),
        .LABEL_LAG(LAG), .GAP_CYCLES(GAP), .BIN_CYCLES(BIN)
    ) dut (
        .clk(clk), .nrst(nrst), .en(en), .start(start),
        .sample_req(sample_req), .sample_idx(sample_idx), .sample_is_test(sample_is_test),
        .sample_valid(sample_valid), .sample_label(sample_label),
        .start_mapping(start_mapping), .class_select_bits(class_select_bits),
        .training_dataset_finished(training_dataset_finished),
        .testing_dataset_finished(testing_dataset_finished),
        .inference_valid(inference_valid), .class_inference(class_inference),
        .correct_count(correct_count), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard of expected start_mapping pulses: cycle and label on the core.
    typedef struct {
        int                 cyc;
        logic [CLASS_W-1:0] csel;
    } sm_t;
    sm_t sb[$];
    sm_t mon_e;

    int trn_fin_n = 0, trn_fin_cyc = -1;
    int tst_fin_n = 0, tst_fin_cyc = -1;

    always @(negedge clk) begin
        if (nrst) begin
            if (start_mapping) begin
                if (sb.size() == 0) begin
                    chk("sm_unexpected", 1, 0);
                end else begin
                    mon_e = sb.pop_front();
                    chk("sm_cycle", cyc, mon_e.cyc);
                    chk("sm_csel", class_select_bits, mon_e.csel);
                end
            end
            if (training_dataset_finished) begin
                trn_fin_n++;
                trn_fin_cyc = cyc;
            end
            if (testing_dataset_finished) begin
                tst_fin_n++;
                tst_fin_cyc = cyc;
            end
        end
    end

    typedef struct {
        logic               is_test;
        int                 idx;
        logic [CLASS_W-1:0] label;
        int                 delay;
        int                 stall;
        logic               spur;
        logic [CLASS_W-1:0] csel;
    } slot_t;
    slot_t tbl[12];

    task automatic wait_start(input int exp_cyc);
        int n = 0;
        while (!sample_req && n < 2000) begin
            tick();
            n++;
        end
        chk("req_start_cycle", cyc, exp_cyc);
    endtask

    task automatic do_slot(input slot_t s, input int exp_start, output int next_start);
        int c;
        wait_start(exp_start);
        c = cyc;
        chk("sample_idx", sample_idx, s.idx);
        chk("sample_is_test", sample_is_test, s.is_test);
        for (int i = 0; i < s.delay; i++) begin
            chk("req_held", sample_req, 1);
            tick();
        end
        sample_valid = 1'b1;
        sample_label = s.label;
        sb.push_back('{c + s.delay + 1 + s.stall, s.csel});
        tick();
        sample_valid = 1'b0;
        sample_label = '0;
        chk("req_drop", sample_req, 0);
        if (s.stall > 0) begin
            en = 1'b0;
            repeat (s.stall) tick();
            en = 1'b1;
        end
        if (s.spur) begin
            tick();
            sample_valid = 1'b1;
            sample_label = 5'd31;
            start = 1'b1;
            tick();
            sample_valid = 1'b0;
            sample_label = '0;
            start = 1'b0;
        end
        next_start = c + s.delay + 2 + s.stall + GAP;
    endtask

    task automatic run_drain(input int s0, input logic [CLASS_W-1:0] c0,
                             input logic [CLASS_W-1:0] c1, input logic inf);
        while (cyc < s0 + 1) tick();
        chk("drain_req", sample_req, 0);
        chk("drain_csel0", class_select_bits, c0);
        if (inf) begin
            inference_valid = 1'b1;
            class_inference = c0;
            tick();
            inference_valid = 1'b0;
        end
        while (cyc < s0 + SLOT + 1) tick();
        chk("drain_csel1", class_select_bits, c1);
        if (inf) begin
            inference_valid = 1'b1;
            class_inference = c1;
            tick();
            inference_valid = 1'b0;
            tick();
            inference_valid = 1'b1;
            class_inference = c1 ^ 5'd1;
            tick();
            inference_valid = 1'b0;
        end
    endtask

    int nxt, tfin;

    initial begin
        //             is_test idx label delay stall spur csel
        tbl[0]  = '{1'b0, 0, 5'd3,  0, 0, 1'b0, 5'd0};
        tbl[1]  = '{1'b0, 1, 5'd7,  5, 0, 1'b0, 5'd0};
        tbl[2]  = '{1'b0, 2, 5'd1,  0, 0, 1'b0, 5'd3};
        tbl[3]  = '{1'b0, 3, 5'd9,  0, 0, 1'b0, 5'd7};
        tbl[4]  = '{1'b1, 0, 5'd4,  0, 0, 1'b0, 5'd0};
        tbl[5]  = '{1'b1, 1, 5'd6,  2, 0, 1'b0, 5'd0};
        tbl[6]  = '{1'b0, 0, 5'd2,  0, 3, 1'b1, 5'd0};
        tbl[7]  = '{1'b0, 1, 5'd5,  1, 0, 1'b0, 5'd0};
        tbl[8]  = '{1'b0, 2, 5'd8,  0, 0, 1'b0, 5'd2};
        tbl[9]  = '{1'b0, 3, 5'd11, 0, 0, 1'b0, 5'd5};
        tbl[10] = '{1'b1, 0, 5'd12, 0, 0, 1'b0, 5'd0};
        tbl[11] = '{1'b0, 0, 5'd1,  0, 0, 1'b0, 5'd0};

        // Reset state
        repeat (3) tick();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_req", sample_req, 0);
        chk("rst_idx", sample_idx, 0);
        chk("rst_is_test", sample_is_test, 0);
        chk("rst_sm", start_mapping, 0);
        chk("rst_csel", class_select_bits, 0);
        chk("rst_trn_fin", training_dataset_finished, 0);
        chk("rst_tst_fin", testing_dataset_finished, 0);
        chk("rst_correct", correct_count, 0);
        nrst = 1'b1;
        en   = 1'b1;
        tick();

        // Run 1: full train / bin / test sequence
        start = 1'b1;
        nxt   = cyc + 1;
        tick();
        start = 1'b0;
        chk("busy_after_start", busy, 1);
        for (int i = 0; i < TRN; i++) do_slot(tbl[i], nxt, nxt);
        run_drain(nxt, 5'd1, 5'd9, 1'b1);
        tfin = nxt + LAG * SLOT;
        while (cyc <= tfin) tick();
        chk("trn_fin_cycle", trn_fin_cyc, tfin);
        chk("trn_fin_count", trn_fin_n, 1);
        nxt = tfin + BIN + 1;
        for (int i = TRN; i < TRN + TST; i++) do_slot(tbl[i], nxt, nxt);
        run_drain(nxt, 5'd4, 5'd6, 1'b1);
        tfin = nxt + LAG * SLOT;
        while (cyc <= tfin + 1) tick();
        chk("tst_fin_cycle", tst_fin_cyc, tfin);
        chk("tst_fin_count", tst_fin_n, 1);
        chk("done_level", done, 1);
        chk("done_busy", busy, 0);
        chk("done_correct", correct_count, ACC * 2);

        // Run 2: restart from DONE, en freeze, spurious valid/start, then reset mid-test
        start = 1'b1;
        nxt   = cyc + 1;
        tick();
        start = 1'b0;
        chk("restart_done", done, 0);
        chk("restart_correct", correct_count, 0);
        for (int i = 6; i < 10; i++) do_slot(tbl[i], nxt, nxt);
        run_drain(nxt, 5'd8, 5'd11, 1'b0);
        tfin = nxt + LAG * SLOT;
        nxt  = tfin + BIN + 1;
        do_slot(tbl[10], nxt, nxt);
        chk("trn_fin_cycle2", trn_fin_cyc, tfin);
        chk("trn_fin_count2", trn_fin_n, 2);
        inference_valid = 1'b1;
        class_inference = 5'd0;
        tick();
        inference_valid = 1'b0;
        tick();
        chk("test_correct", correct_count, ACC);
        nrst = 1'b0;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_req", sample_req, 0);
        chk("arst_csel", class_select_bits, 0);
        chk("arst_correct", correct_count, 0);
        repeat (3) tick();
        chk("arst_no_tst_fin", tst_fin_n, 1);
        chk("arst_sb_empty", sb.size(), 0);
        nrst = 1'b1;
        tick();
        start = 1'b1;
        nxt   = cyc + 1;
        tick();
        start = 1'b0;
        do_slot(tbl[11], nxt, nxt);
        repeat (3) tick();
        chk("final_sb_empty", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
